// File: rtl/traffic_lamp_monitor.sv
// traffic_lamp_monitor
//   Receive-side checker for a six-lamp intersection (NR/NG/NY/ER/EG/EY).
//   It decodes the lamps into a phase and counts the enable ticks spent in that
//   phase. It checks that the phase sequence is legal and that each green and
//   yellow phase lasts its minimum time. The first fault is latched until R.
//   The block only observes the lamps and never drives them.
//
//   Optional build macro: MONITOR_STALL_EN enables a stall fault (code 5) when a
//   phase dwells for STALL_LIMIT ticks.
//
// Ports
//   clk         system clock, rising edge
//   R           asynchronous active-high reset
//   in_EN       tick enable (same strobe as the controller's interval counter)
//   NR,NG,NY    north lamps
//   ER,EG,EY    east lamps
//   phase       0 UNKNOWN,1 NG,2 NY,3 EG,4 EY,5 ALLRED,7 FAULT
//   phase_chg   1-cycle pulse on each accepted phase change
//   dwell       ticks spent in the current phase (saturating)
//   cycles      completed east->north handovers (wraps)
//   fault       sticky fault flag
//   fault_code  first fault: 1 illegal lamps,2 bad transition,3 short green,
//               4 short yellow,5 stall; 0 when no fault
module traffic_lamp_monitor #(
    parameter int CNT_W       = 8,
    parameter int MIN_GREEN   = 8,
    parameter int MIN_YELLOW  = 3,
    parameter int STALL_LIMIT = 200
) (
    input  logic             clk,
    input  logic             R,
    input  logic             in_EN,
    input  logic             NR,
    input  logic             NG,
    input  logic             NY,
    input  logic             ER,
    input  logic             EG,
    input  logic             EY,
    output logic [2:0]       phase,
    output logic             phase_chg,
    output logic [CNT_W-1:0] dwell,
    output logic [7:0]       cycles,
    output logic             fault,
    output logic [2:0]       fault_code
);

    // PH_ILLEGAL is used only as a decode result and is never stored in p.
    typedef enum logic [2:0] {
        PH_UNKNOWN = 3'd0,
        PH_NG      = 3'd1,
        PH_NY      = 3'd2,
        PH_EG      = 3'd3,
        PH_EY      = 3'd4,
        PH_ALLRED  = 3'd5,
        PH_ILLEGAL = 3'd6,
        PH_FAULT   = 3'd7
    } phase_t;

    localparam logic [CNT_W-1:0] MIN_G    = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MIN_Y    = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W:0]   STALL_M1 = (CNT_W+1)'(STALL_LIMIT - 1);

`ifdef MONITOR_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    phase_t d, p;
    logic   legal_tr, short_time, short_green, stall_hit;

    assign phase = p;

    // Only these exact one-lamp-per-road patterns are legal.
    always_comb begin
        case ({NR, NG, NY, ER, EG, EY})
            6'b010_100: d = PH_NG;
            6'b001_100: d = PH_NY;
            6'b100_010: d = PH_EG;
            6'b100_001: d = PH_EY;
            6'b100_100: d = PH_ALLRED;
            default:    d = PH_ILLEGAL;
        endcase
    end

    always_comb begin
        legal_tr    = 1'b0;
        short_time  = 1'b0;
        short_green = 1'b0;
        case (p)
            PH_NG:     begin legal_tr = (d == PH_NY);
                             short_green = 1'b1; short_time = (dwell < MIN_G); end
            PH_NY:     begin legal_tr = (d == PH_EG) || (d == PH_ALLRED);
                             short_time = (dwell < MIN_Y); end
            PH_EG:     begin legal_tr = (d == PH_EY);
                             short_green = 1'b1; short_time = (dwell < MIN_G); end
            PH_EY:     begin legal_tr = (d == PH_NG) || (d == PH_ALLRED);
                             short_time = (dwell < MIN_Y); end
            PH_ALLRED: legal_tr = (d == PH_NG) || (d == PH_EG);
            default:   legal_tr = 1'b0;
        endcase
    end

    // The stall fault fires on the tick that would bring dwell up to STALL_LIMIT.
    assign stall_hit = STALL_EN && in_EN && ({1'b0, dwell} >= STALL_M1);

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            p          <= PH_UNKNOWN;
            phase_chg  <= 1'b0;
            dwell      <= '0;
            cycles     <= '0;
            fault      <= 1'b0;
            fault_code <= 3'd0;
        end else begin
            phase_chg <= 1'b0;
            if (p == PH_FAULT) begin
                // Absorbing state: everything stays frozen until R.
            end else if (d == PH_ILLEGAL) begin
                p <= PH_FAULT; fault <= 1'b1; fault_code <= 3'd1;
            end else if (p == PH_UNKNOWN) begin
                // The first legal pattern is adopted without any checks.
                p     <= d;
                dwell <= '0;
            end else if (d == p) begin
                if (stall_hit) begin
                    p <= PH_FAULT; fault <= 1'b1; fault_code <= 3'd5;
                end else if (in_EN && (dwell != '1)) begin
                    dwell <= dwell + 1'b1;
                end
            end else if (!legal_tr) begin
                p <= PH_FAULT; fault <= 1'b1; fault_code <= 3'd2;
            end else if (short_time) begin
                p <= PH_FAULT; fault <= 1'b1;
                fault_code <= short_green ? 3'd3 : 3'd4;
            end else begin
                // An accepted change clears dwell, even if in_EN is also high.
                p         <= d;
                dwell     <= '0;
                phase_chg <= 1'b1;
                if (p == PH_EY) cycles <= cycles + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
module tb_traffic_lamp_monitor;

    logic       clk = 1'b0;
    logic       R   = 1'b1;
    logic       in_EN = 1'b0;
    logic       NR = 1'b0, NG = 1'b0, NY = 1'b0, ER = 1'b0, EG = 1'b0, EY = 1'b0;
    logic [2:0] phase;
    logic       phase_chg;
    logic [7:0] dwell;
    logic [7:0] cycles;
    logic       fault;
    logic [2:0] fault_code;

    traffic_lamp_monitor dut (
        .clk(clk), .R(R), .in_EN(in_EN),
        .NR(NR), .NG(NG), .NY(NY), .ER(ER), .EG(EG), .EY(EY),
        .phase(phase), .phase_chg(phase_chg), .dwell(dwell), .cycles(cycles),
        .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    // Lamp patterns as {NR,NG,NY,ER,EG,EY}
    localparam logic [5:0] L_NG  = 6'b010_100;
    localparam logic [5:0] L_NY  = 6'b001_100;
    localparam logic [5:0] L_EG  = 6'b100_010;
    localparam logic [5:0] L_EY  = 6'b100_001;
    localparam logic [5:0] L_AR  = 6'b100_100;
    localparam logic [5:0] L_GG  = 6'b010_010;
    localparam logic [5:0] L_OFF = 6'b000_000;

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors < 60) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input int ph, input int chg, input int dw,
                             input int cy, input int flt, input int code);
        cmp({name, ".phase"},      int'(phase),      ph);
        cmp({name, ".phase_chg"},  int'(phase_chg),  chg);
        cmp({name, ".dwell"},      int'(dwell),      dw);
        cmp({name, ".cycles"},     int'(cycles),     cy);
        cmp({name, ".fault"},      int'(fault),      flt);
        cmp({name, ".fault_code"}, int'(fault_code), code);
    endtask

    // ---------------- reference model ----------------
    // Phases as integers: 0 unknown, 1 NG, 2 NY, 3 EG, 4 EY, 5 all-red, 7 fault.
    int m_phase, m_dwell, m_cycles, m_code, m_chg;
    bit allowed [8][8];
    int min_need [8];
    int phase_of [3][3]; // [north colour][east colour], colour 0 red 1 green 2 yellow

    function automatic int colour(input logic [2:0] road); // road = {R,G,Y}
        if ($countones(road) != 1) return -1;
        if (road[2]) return 0;
        if (road[1]) return 1;
        return 2;
    endfunction

    function automatic int lamp_phase(input logic [5:0] l);
        int n, e;
        n = colour(l[5:3]);
        e = colour(l[2:0]);
        if (n < 0 || e < 0) return -1;
        return phase_of[n][e];
    endfunction

    task automatic m_reset();
        m_phase = 0; m_dwell = 0; m_cycles = 0; m_code = 0; m_chg = 0;
    endtask

    task automatic m_trip(input int code);
        m_code  = code;
        m_phase = 7;
    endtask

    task automatic m_edge(input logic [5:0] l, input logic en);
        int dd;
        dd = lamp_phase(l);
        m_chg = 0;
        if (m_code != 0) return;
        if (dd < 0) m_trip(1);
        else if (m_phase == 0) begin m_phase = dd; m_dwell = 0; end
        else if (dd == m_phase) begin
`ifdef MONITOR_STALL_EN
            if (en && m_dwell + 1 >= 200) begin m_trip(5); return; end
`endif
            if (en && m_dwell < 255) m_dwell++;
        end
        else if (!allowed[m_phase][dd]) m_trip(2);
        else if (m_dwell < min_need[m_phase]) m_trip((m_phase == 1 || m_phase == 3) ? 3 : 4);
        else begin
            if (m_phase == 4) m_cycles = (m_cycles + 1) % 256;
            m_phase = dd; m_dwell = 0; m_chg = 1;
        end
    endtask

    task automatic check_model(input string name);
        check_all(name, m_phase, m_chg, m_dwell, m_cycles, (m_code != 0) ? 1 : 0, m_code);
    endtask

    // ---------------- drivers (called at posedge+1) ----------------
    task automatic step(input logic [5:0] l, input logic en);
        {NR, NG, NY, ER, EG, EY} = l;
        in_EN = en;
        m_edge(l, en);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 R = 1'b1;
        m_reset();
        #1;
        R = 1'b0;
    endtask

    typedef struct {
        logic [5:0] lamps;
        logic       en;
        int         reps;
        int         ph, chg, dw, cy, flt, code;
    } vec_t;

    vec_t vecs[$];
    logic [5:0] lamp_of [8];

    function automatic int next_phase(input int c);
        case (c)
            1: return 2;
            2: return ($urandom_range(0, 1) != 0) ? 3 : 5;
            3: return 4;
            4: return ($urandom_range(0, 1) != 0) ? 1 : 5;
            default: return ($urandom_range(0, 1) != 0) ? 1 : 3;
        endcase
    endfunction

    initial begin
        int cur, r, hold;

        allowed[1][2] = 1; allowed[2][3] = 1; allowed[2][5] = 1; allowed[3][4] = 1;
        allowed[4][1] = 1; allowed[4][5] = 1; allowed[5][1] = 1; allowed[5][3] = 1;
        min_need[1] = 8; min_need[2] = 3; min_need[3] = 8; min_need[4] = 3;
        phase_of[0][0] = 5; phase_of[1][0] = 1; phase_of[2][0] = 2;
        phase_of[0][1] = 3; phase_of[0][2] = 4;
        phase_of[1][1] = -1; phase_of[1][2] = -1; phase_of[2][1] = -1; phase_of[2][2] = -1;
        lamp_of[1] = L_NG; lamp_of[2] = L_NY; lamp_of[3] = L_EG;
        lamp_of[4] = L_EY; lamp_of[5] = L_AR;
        m_reset();

        // Reset state, with R held over a clock edge
        @(posedge clk); #1;
        check_all("reset", 0, 0, 0, 0, 0, 0);
        R = 1'b0;

        // Nominal sequence: NG 10, NY 3, ALLRED 1, EG 8, EY 3, NG
        //              lamps  en   reps ph chg dw  cy flt code
        vecs.push_back('{L_NG, 1'b1, 1,  1, 0,  0,  0, 0, 0});
        vecs.push_back('{L_NG, 1'b1, 10, 1, 0,  10, 0, 0, 0});
        vecs.push_back('{L_NG, 1'b0, 2,  1, 0,  10, 0, 0, 0});
        vecs.push_back('{L_NY, 1'b1, 1,  2, 1,  0,  0, 0, 0});
        vecs.push_back('{L_NY, 1'b1, 3,  2, 0,  3,  0, 0, 0});
        vecs.push_back('{L_AR, 1'b1, 1,  5, 1,  0,  0, 0, 0});
        vecs.push_back('{L_AR, 1'b1, 1,  5, 0,  1,  0, 0, 0});
        vecs.push_back('{L_EG, 1'b1, 1,  3, 1,  0,  0, 0, 0});
        vecs.push_back('{L_EG, 1'b1, 8,  3, 0,  8,  0, 0, 0});
        vecs.push_back('{L_EY, 1'b1, 1,  4, 1,  0,  0, 0, 0});
        vecs.push_back('{L_EY, 1'b1, 3,  4, 0,  3,  0, 0, 0});
        vecs.push_back('{L_NG, 1'b1, 1,  1, 1,  0,  1, 0, 0});
        vecs.push_back('{L_NG, 1'b1, 4,  1, 0,  4,  1, 0, 0});
        foreach (vecs[i]) begin
            repeat (vecs[i].reps) step(vecs[i].lamps, vecs[i].en);
            check_all($sformatf("vec%0d", i), vecs[i].ph, vecs[i].chg, vecs[i].dw,
                      vecs[i].cy, vecs[i].flt, vecs[i].code);
        end

        // Async reset mid-phase clears outputs before the next clock edge
        #2 R = 1'b1;
        m_reset();
        #1;
        check_all("async_reset", 0, 0, 0, 0, 0, 0);
        R = 1'b0;
        step(L_NY, 1'b1);
        check_all("post_reset_load", 2, 0, 0, 0, 0, 0);

        // Short green
        do_reset();
        step(L_NG, 1'b1);
        repeat (5) step(L_NG, 1'b1);
        step(L_NY, 1'b1);
        check_all("short_green", 7, 0, 5, 0, 1, 3);
        repeat (4) step(L_NY, 1'b1);
        check_all("short_green_hold", 7, 0, 5, 0, 1, 3);

        // Short yellow
        do_reset();
        step(L_NG, 1'b1);
        repeat (8) step(L_NG, 1'b1);
        step(L_NY, 1'b1);
        repeat (2) step(L_NY, 1'b1);
        step(L_EG, 1'b1);
        check_all("short_yellow", 7, 0, 2, 0, 1, 4);

        // Bad transition, then illegal lamps must not overwrite the code
        do_reset();
        step(L_NG, 1'b1);
        repeat (9) step(L_NG, 1'b1);
        step(L_EG, 1'b1);
        check_all("bad_trans", 7, 0, 9, 0, 1, 2);
        step(L_GG, 1'b1);
        check_all("bad_trans_keep", 7, 0, 9, 0, 1, 2);

        // Illegal lamps mid-phase and straight out of reset
        do_reset();
        step(L_NG, 1'b1);
        repeat (3) step(L_NG, 1'b1);
        step(L_GG, 1'b1);
        check_all("illegal_gg", 7, 0, 3, 0, 1, 1);
        do_reset();
        step(L_OFF, 1'b0);
        check_all("illegal_off", 7, 0, 0, 0, 1, 1);

        // Handover counter wraps 255 -> 0
        do_reset();
        step(L_NG, 1'b1);
        for (int k = 0; k < 256; k++) begin
            repeat (8) step(L_NG, 1'b1);
            step(L_NY, 1'b1); repeat (3) step(L_NY, 1'b1);
            step(L_EG, 1'b1); repeat (8) step(L_EG, 1'b1);
            step(L_EY, 1'b1); repeat (3) step(L_EY, 1'b1);
            step(L_NG, 1'b1);
            if (k == 254) cmp("cycles_255", int'(cycles), 255);
        end
        check_all("cycles_wrap", 1, 1, 0, 0, 0, 0);

        // Long dwell: stall fault or saturation
        do_reset();
        step(L_EG, 1'b1);
`ifdef MONITOR_STALL_EN
        repeat (199) step(L_EG, 1'b1);
        check_all("pre_stall", 3, 0, 199, 0, 0, 0);
        step(L_EG, 1'b1);
        check_all("stall", 7, 0, 199, 0, 1, 5);
`else
        repeat (300) step(L_EG, 1'b1);
        check_all("saturate", 3, 0, 255, 0, 0, 0);
`endif

        // Randomized walk against the reference model
        do_reset();
        cur = $urandom_range(1, 5);
        for (int it = 0; it < 500; it++) begin
            r = $urandom_range(0, 99);
            if (m_code != 0 || r < 4) begin
                do_reset();
                check_model("rand_reset");
                cur = $urandom_range(1, 5);
            end else if (r < 8) begin
                step(6'($urandom), 1'($urandom_range(0, 1)));
                check_model("rand_lamps");
            end else if (r < 12) begin
                cur = $urandom_range(1, 5);
                step(lamp_of[cur], 1'b1);
                check_model("rand_jump");
            end else begin
                hold = $urandom_range(0, 11);
                for (int h = 0; h < hold; h++) begin
                    step(lamp_of[cur], 1'($urandom_range(0, 3) != 0));
                    check_model("rand_hold");
                end
                cur = next_phase(cur);
                step(lamp_of[cur], 1'($urandom_range(0, 1)));
                check_model("rand_move");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
